rx_fifo: RTL
============

Name: rx_fifo

Overview:
- Byte buffer between the UART receiver `rx` and `interface_circuit`.
- Captures every byte flagged by the receiver's `o_rx_done` pulse and holds it until the interface pops it.
- Prevents byte loss when operands and opcode arrive back-to-back while the interface is still busy with a previous ALU result.
- Reports occupancy, full/empty status and a sticky overflow flag.

Parameters:
- WIDTH_WORD, 8: width of one stored word; matches the receiver data width.
- DEPTH, 16: number of storage entries; must be a power of two, minimum 2.
- ADDR_BITS, 4: log2(DEPTH); pointer width.

Ports:
- i_clock  input  1  system clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_rx_done  input  1  write strobe; one-cycle pulse from the receiver.
- i_data_rx  input  WIDTH_WORD  byte to store; valid when i_rx_done=1.
- i_read  input  1  pop request from the consumer.
- i_clear_overflow  input  1  clears the sticky overflow flag.
- o_data  output  WIDTH_WORD  popped / head word.
- o_valid  output  1  o_data qualifier (meaning depends on mode, see Optional Feature).
- o_empty  output  1  high when count==0.
- o_full  output  1  high when count==DEPTH.
- o_count  output  ADDR_BITS+1  current occupancy, 0..DEPTH.
- o_overflow  output  1  sticky: a write was dropped.

Behaviour:
- Reset:
  - Only one clock; reset is synchronous and active-high on i_clock.
  - On a rising edge with i_reset=1: write pointer=0, read pointer=0, count=0, o_data=0, o_valid=0, o_overflow=0.
  - Result: o_empty=1, o_full=0, o_count=0.
  - Storage contents are not cleared.
  - Reset during any activity discards all buffered words; the next cycle behaves as after power-up.
- Write accepted when i_rx_done=1 and (count<DEPTH, or a read is accepted in the same cycle). Accepted write stores i_data_rx at the write pointer and increments the pointer modulo DEPTH.
- Read accepted when i_read=1 and count>0. Accepted read advances the read pointer modulo DEPTH.
- Count update per cycle: +1 on write only, -1 on read only, unchanged on both or neither.
- Pointers wrap from DEPTH-1 to 0 with no gap; the full-to-empty cycle is exercised continuously.
- o_empty, o_full and o_count are registered and reflect state after the current edge; they are never combinational on inputs.
- Read when empty: ignored; no pointer or count change, o_valid stays 0, o_data holds its value. No error flag.
- Write when full with no accepted read: word dropped, storage unchanged, o_overflow set to 1 on that edge.
- Write when full with an accepted read in the same cycle: both accepted; count stays DEPTH; no overflow.
- Write and read in the same cycle while empty:
  - Standard mode: read ignored, write accepted, count becomes 1.
- o_overflow:
  - Remains 1 until i_clear_overflow=1 or reset.
  - If clear and a new dropped write occur in the same cycle, set wins (o_overflow=1).
- i_rx_done held high for several cycles: each cycle counts as a separate write. The receiver guarantees single-cycle pulses.

Optional Feature:
- Macro: RX_FIFO_FWFT_EN.
- Not defined (standard mode):
  - An accepted read loads o_data from the head entry on that edge.
  - o_valid=1 for exactly the following cycle, otherwise 0.
  - Read latency is 1 cycle.
  - o_data holds the last popped word between reads.
- Defined (first-word fall-through):
  - o_data continuously presents the head entry; o_valid = NOT o_empty.
  - A write into an empty FIFO makes o_valid=1 and o_data=written word on the cycle after the write edge.
  - i_read acts as an acknowledge: the next edge advances to the following word, or drops o_valid if that was the last word.
  - i_read while o_valid=0 is ignored.
  - Simultaneous write and read while empty: read ignored, write accepted.
  - o_data while empty is don't-care; the bench must not check it.

Test Plan:
- Reset then idle:
  - Stimulus: i_reset=1 for 2 cycles, then release.
  - Required: o_empty=1, o_full=0, o_count=0, o_valid=0, o_overflow=0, o_data=0.
- Ordered transfer:
  - Stimulus: write 0x12, 0x34, 0x56 on pulses 3 cycles apart, then i_read for 3 single cycles.
  - Required: o_data sequence 0x12, 0x34, 0x56, each with one o_valid cycle; o_count 3→2→1→0.
- Full and overflow:
  - Stimulus: write 16 words 0x00..0x0F, then write 0xAA.
  - Required: o_full=1 after the 16th write and o_overflow=1 after 0xAA.
  - Reading all 16 words returns 0x00..0x0F; 0xAA is never seen.
  - i_clear_overflow=1 for one cycle drops o_overflow to 0.
- Simultaneous read and write at full:
  - Stimulus: with 16 words stored, i_rx_done=1 with 0x77 and i_read=1 in the same cycle.
  - Required: o_count stays 16, o_overflow stays 0, 0x77 is read out last.
- Wrap-around:
  - Stimulus: 40 write-then-read pairs with data 0x80+n.
  - Required: every read returns its matching value, o_count alternates 1/0, no overflow.
- Reset mid-operation (both builds):
  - Stimulus: store 5 words, assert i_reset for 1 cycle.
  - Required: o_count=0, o_empty=1, o_valid=0.
  - A following write of 0x3C then read returns 0x3C.
  - With RX_FIFO_FWFT_EN, 0x3C appears on o_data one cycle after its write, before any i_read.

Source files
------------

// File: rtl/rx_fifo_if.sv
// Receiver-to-consumer handshake bundle for rx_fifo: write strobe/data, pop request,
// overflow clear, and the head word with its status flags.
interface rx_fifo_if #(
  parameter int WIDTH_WORD = 8,
  parameter int ADDR_BITS  = 4
);
  logic                  i_rx_done;
  logic [WIDTH_WORD-1:0] i_data_rx;
  logic                  i_read;
  logic                  i_clear_overflow;
  logic [WIDTH_WORD-1:0] o_data;
  logic                  o_valid;
  logic                  o_empty;
  logic                  o_full;
  logic [ADDR_BITS:0]    o_count;
  logic                  o_overflow;

  modport master (
    output i_rx_done, i_data_rx, i_read, i_clear_overflow,
    input  o_data, o_valid, o_empty, o_full, o_count, o_overflow
  );

  modport slave (
    input  i_rx_done, i_data_rx, i_read, i_clear_overflow,
    output o_data, o_valid, o_empty, o_full, o_count, o_overflow
  );
endinterface

// File: rtl/rx_fifo.sv
// Byte FIFO between UART rx and interface_circuit; RX_FIFO_FWFT_EN selects fall-through output.
// Latency: standard pop data one cycle after i_read; FWFT head visible one cycle after write.
// Backpressure: none upstream; writes while full (no same-cycle pop) are dropped and set o_overflow.
module rx_fifo #(
  parameter int WIDTH_WORD = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_BITS  = 4
) (
  input logic     i_clock,
  input logic     i_reset,
  rx_fifo_if.slave bus
);

  localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS+1)'(DEPTH);

  logic [WIDTH_WORD-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0]  wr_ptr;
  logic [ADDR_BITS-1:0]  rd_ptr;
  logic [ADDR_BITS:0]    count;
  logic [ADDR_BITS:0]    count_nxt;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  wr_drop;
  logic                  empty_q;
  logic                  full_q;
  logic                  overflow_q;

  // A pop in the same cycle frees the slot, so a write at full is still taken.
  always_comb begin
    rd_acc    = bus.i_read && (count != '0);
    wr_acc    = bus.i_rx_done && ((count != FULL_COUNT) || rd_acc);
    wr_drop   = bus.i_rx_done && !wr_acc;
    count_nxt = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.i_data_rx;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count   <= count_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == FULL_COUNT);
      // A fresh drop outranks a clear in the same cycle.
      if (wr_drop) begin
        overflow_q <= 1'b1;
      end else if (bus.i_clear_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

`ifdef RX_FIFO_FWFT_EN
  assign bus.o_data  = mem[rd_ptr];
  assign bus.o_valid = !empty_q;
`else
  logic [WIDTH_WORD-1:0] data_q;
  logic                  valid_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_acc;
      if (rd_acc) begin
        data_q <= mem[rd_ptr];
      end
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
`endif

  assign bus.o_empty    = empty_q;
  assign bus.o_full     = full_q;
  assign bus.o_count    = count;
  assign bus.o_overflow = overflow_q;

endmodule
